// File: rtl/arb_pkg.sv
// Shared sizing, state encoding and one-hot helper for the round-robin grant arbiter.
package arb_pkg;

    localparam int N_REQ    = 8;
    localparam int IDX_W    = 3;
    localparam int HOLD_MAX = 16;
    localparam int HOLD_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... modulo N_REQ.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0]   lsh;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // rot[0] is the request at ptr, so the encoder's lowest hit is the winner's offset
    assign lsh = (IDX_W+1)'(N_REQ) - {1'b0, ptr_i};
    assign rot = (req_i >> ptr_i) | (req_i << lsh);

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign any_o = |req_i;
    assign idx_o = off + ptr_i;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin owner arbiter with hold-until-release and a one-cycle break-before-make gap.
// Optional forced revoke after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             tmo
);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic [N_REQ-1:0] gnt_q;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             release_c;
    logic             revoke_c;

    rr_pick u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // a dropped request and an explicit release on the same cycle are one event
    assign release_c = rel || !req[idx_q];
    assign ptr_d     = idx_q + IDX_W'(1);

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q;
    logic              tmo_q;
    assign revoke_c = (hold_q == HOLD_W'(HOLD_MAX - 1));
    assign tmo      = tmo_q;
`else
    assign revoke_c = 1'b0;
    assign tmo      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            gnt_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            case (state_q)
                IDLE, GAP: begin
                    if (pick_any) begin
                        state_q <= GRANT;
                        idx_q   <= pick_idx;
                        valid_q <= 1'b1;
                        gnt_q   <= idx_onehot(pick_idx);
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_c || revoke_c) begin
                        state_q <= GAP;
                        valid_q <= 1'b0;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
                        tmo_q   <= revoke_c && !release_c;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= hold_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter; expectations are queued as stimulus is driven.
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       tmo;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       tmo;
    } exp_t;

    typedef struct {
        bit         rst;
        logic [7:0] req;
        bit         rel;
        bit         v;
        int         idx;
        bit         t;
    } step_t;

    exp_t sb[$];

    rr_grant_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input bit v, input int idx, input bit t);
        exp_t e;
        e.valid = v;
        e.idx   = 3'(idx);
        e.gnt   = v ? (8'h01 << idx) : 8'h00;
        e.tmo   = t;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        req   = 8'hFF;
        rel   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk(1'b0, 0, 1'b0));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || tmo !== e.tmo) begin
                n_err++;
                $display("FAIL reset[%0d]: got gnt=%h idx=%0d valid=%b tmo=%b, expected gnt=%h idx=%0d valid=%b tmo=%b",
                         k, gnt, gnt_idx, gnt_valid, tmo, e.gnt, e.idx, e.valid, e.tmo);
            end
        end
        req   = 8'h00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t  e;
        step_t tbl[8] = '{
            '{1, 8'h10, 0, 1, 4, 0},
            '{1, 8'h10, 1, 0, 4, 0},
            '{1, 8'h31, 0, 1, 5, 0},
            '{1, 8'h31, 1, 0, 5, 0},
            '{1, 8'h00, 0, 0, 5, 0},
            '{1, 8'h21, 0, 1, 0, 0},
            '{1, 8'h00, 0, 0, 0, 0},
            '{1, 8'h00, 0, 0, 0, 0}
        };
        do_reset();
        foreach (tbl[k]) begin
            rst_n = tbl[k].rst;
            req   = tbl[k].req;
            rel   = tbl[k].rel;
            sb.push_back(mk(tbl[k].v, tbl[k].idx, tbl[k].t));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || tmo !== e.tmo) begin
                n_err++;
                $display("FAIL single[%0d]: got gnt=%h idx=%0d valid=%b tmo=%b, expected gnt=%h idx=%0d valid=%b tmo=%b",
                         k, gnt, gnt_idx, gnt_valid, tmo, e.gnt, e.idx, e.valid, e.tmo);
            end
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        do_reset();
        req = 8'hFF;
        for (int s = 0; s < 18; s++) begin
            rel = (s % 2) == 1;
            sb.push_back(mk((s % 2) == 0, (s / 2) % 8, 1'b0));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || tmo !== e.tmo) begin
                n_err++;
                $display("FAIL rotation[%0d]: got gnt=%h idx=%0d valid=%b tmo=%b, expected gnt=%h idx=%0d valid=%b tmo=%b",
                         s, gnt, gnt_idx, gnt_valid, tmo, e.gnt, e.idx, e.valid, e.tmo);
            end
        end
        rel = 1'b0;
        req = 8'h00;
        tick();
    endtask

    task automatic test_wrap_skip();
        exp_t  e;
        step_t tbl[10] = '{
            '{1, 8'h40, 0, 1, 6, 0},
            '{1, 8'h06, 1, 0, 6, 0},
            '{1, 8'h06, 0, 1, 1, 0},
            '{1, 8'hFF, 0, 1, 1, 0},
            '{1, 8'h04, 0, 0, 1, 0},
            '{1, 8'h04, 0, 1, 2, 0},
            '{1, 8'hFC, 0, 1, 2, 0},
            '{1, 8'h00, 0, 0, 2, 0},
            '{1, 8'h00, 0, 0, 2, 0},
            '{1, 8'h00, 1, 0, 2, 0}
        };
        do_reset();
        foreach (tbl[k]) begin
            rst_n = tbl[k].rst;
            req   = tbl[k].req;
            rel   = tbl[k].rel;
            sb.push_back(mk(tbl[k].v, tbl[k].idx, tbl[k].t));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || tmo !== e.tmo) begin
                n_err++;
                $display("FAIL wrap_skip[%0d]: got gnt=%h idx=%0d valid=%b tmo=%b, expected gnt=%h idx=%0d valid=%b tmo=%b",
                         k, gnt, gnt_idx, gnt_valid, tmo, e.gnt, e.idx, e.valid, e.tmo);
            end
        end
        rel = 1'b0;
    endtask

    task automatic test_mid_reset();
        exp_t  e;
        step_t tbl[5] = '{
            '{1, 8'h08, 0, 1, 3, 0},
            '{0, 8'h88, 0, 0, 0, 0},
            '{1, 8'h88, 0, 1, 3, 0},
            '{1, 8'h00, 0, 0, 3, 0},
            '{1, 8'h00, 0, 0, 3, 0}
        };
        do_reset();
        foreach (tbl[k]) begin
            rst_n = tbl[k].rst;
            req   = tbl[k].req;
            rel   = tbl[k].rel;
            sb.push_back(mk(tbl[k].v, tbl[k].idx, tbl[k].t));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || tmo !== e.tmo) begin
                n_err++;
                $display("FAIL mid_reset[%0d]: got gnt=%h idx=%0d valid=%b tmo=%b, expected gnt=%h idx=%0d valid=%b tmo=%b",
                         k, gnt, gnt_idx, gnt_valid, tmo, e.gnt, e.idx, e.valid, e.tmo);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_hold();
        exp_t e;
        int   n;
        do_reset();
        req = 8'h01;
        rel = 1'b0;
`ifdef ARB_TIMEOUT_EN
        n = 18;
        for (int k = 1; k <= 16; k++) sb.push_back(mk(1'b1, 0, 1'b0));
        sb.push_back(mk(1'b0, 0, 1'b1));
        sb.push_back(mk(1'b1, 0, 1'b0));
`else
        n = 40;
        for (int k = 1; k <= 40; k++) sb.push_back(mk(1'b1, 0, 1'b0));
`endif
        for (int k = 0; k < n; k++) begin
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid || tmo !== e.tmo) begin
                n_err++;
                $display("FAIL hold[%0d]: got gnt=%h idx=%0d valid=%b tmo=%b, expected gnt=%h idx=%0d valid=%b tmo=%b",
                         k, gnt, gnt_idx, gnt_valid, tmo, e.gnt, e.idx, e.valid, e.tmo);
            end
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap_skip();
        test_mid_reset();
        test_hold();
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
